// File: rtl/ghffe_pkg.sv
// rtl/ghffe_pkg.sv - shared bin/magnitude widths and peak-picker state encoding
package ghffe_pkg;

  localparam int BIN_ADDR_W = 11;
  localparam int MAG_W      = 16;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    SCAN       = 2'd1,
    REPORT     = 2'd2
  } peak_state_t;

endpackage

// File: rtl/note_stabilizer.sv
// rtl/note_stabilizer.sv - debounces per-frame peaks into a stable note output
module note_stabilizer
  import ghffe_pkg::*;
#(
  parameter int ADDR_W        = BIN_ADDR_W,
  parameter int DATA_W        = MAG_W,
  parameter int STABLE_FRAMES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] peak_bin,
  input  logic [DATA_W-1:0] peak_mag,
  input  logic              peak_valid,
  input  logic [DATA_W-1:0] threshold,
  output logic [ADDR_W-1:0] note_bin,
  output logic              note_on,
  output logic              note_change
);

  localparam logic [3:0] FULL = 4'(STABLE_FRAMES);

  logic [ADDR_W-1:0] cand_bin, cand_bin_next, bin_diff;
  logic              cand_silent, cand_silent_next;
  logic              hit, near;
  logic [3:0]        count, count_next, count_inc;

  // A silence candidate never matches a hit; neighbouring bins extend the current candidate.
  always_comb begin
    hit              = peak_mag >= threshold;
    bin_diff         = (peak_bin > cand_bin) ? (peak_bin - cand_bin) : (cand_bin - peak_bin);
    near             = bin_diff <= ADDR_W'(1);
    count_inc        = (count >= FULL) ? FULL : (count + 4'd1);
    cand_bin_next    = cand_bin;
    cand_silent_next = cand_silent;
    count_next       = count_inc;
    if (hit) begin
      if (count == 4'd0 || cand_silent || !near) begin
        cand_bin_next    = peak_bin;
        cand_silent_next = 1'b0;
        count_next       = 4'd1;
      end
    end else if (!cand_silent) begin
      cand_silent_next = 1'b1;
      count_next       = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_bin    <= '0;
      cand_silent <= 1'b0;
      count       <= 4'd0;
      note_bin    <= '0;
      note_on     <= 1'b0;
      note_change <= 1'b0;
    end else begin
      note_change <= 1'b0;
      if (peak_valid) begin
        cand_bin    <= cand_bin_next;
        cand_silent <= cand_silent_next;
        count       <= count_next;
        if (count_next == FULL) begin
          if (hit && (!note_on || cand_bin_next != note_bin)) begin
            note_on     <= 1'b1;
            note_bin    <= cand_bin_next;
            note_change <= 1'b1;
          end else if (!hit && note_on) begin
            note_on     <= 1'b0;
            note_change <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-frame in-window peak picker feeding the note stabiliser
module fft_peak_detect
  import ghffe_pkg::*;
#(
  parameter int ADDR_W        = BIN_ADDR_W,
  parameter int DATA_W        = MAG_W,
  parameter int BIN_LO        = 2,
  parameter int BIN_HI        = 1023,
  parameter int STABLE_FRAMES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hwe,
  input  logic [11:0]       haddr,
  input  logic [DATA_W-1:0] hdata,
  input  logic [DATA_W-1:0] threshold,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              peak_valid,
  output logic [ADDR_W-1:0] note_bin,
  output logic              note_on,
  output logic              note_change
);

  localparam logic [ADDR_W-1:0] LO   = ADDR_W'(BIN_LO);
  localparam logic [ADDR_W-1:0] HI   = ADDR_W'(BIN_HI);
  localparam logic [ADDR_W-1:0] LAST = '1;

  peak_state_t       state, state_next;
  logic [ADDR_W-1:0] a, exp_addr, exp_next, run_bin, run_bin_next;
  logic [DATA_W-1:0] run_max, run_max_next;
  logic              in_win, fresh, unused_haddr;

  assign a            = haddr[ADDR_W-1:0];
  assign unused_haddr = &{1'b0, haddr};
  assign in_win       = (a >= LO) && (a <= HI);

  always_comb begin
    state_next   = state;
    exp_next     = exp_addr;
    run_max_next = run_max;
    run_bin_next = run_bin;
    // Bin 0 restarts a frame from any state, including REPORT and a broken SCAN.
    fresh        = hwe && (a == '0) && (state != SCAN || a != exp_addr);
    if (state == SCAN && hwe) begin
      if (a != exp_addr) begin
        state_next = WAIT_START;
      end else begin
        exp_next = exp_addr + 1'b1;
        if (in_win && hdata > run_max) begin
          run_max_next = hdata;
          run_bin_next = a;
        end
        if (a == LAST) state_next = REPORT;
      end
    end else if (state == REPORT) begin
      state_next = WAIT_START;
    end
    if (fresh) begin
      state_next   = SCAN;
      exp_next     = ADDR_W'(1);
      run_max_next = in_win ? hdata : '0;
      run_bin_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= WAIT_START;
      exp_addr   <= '0;
      run_max    <= '0;
      run_bin    <= '0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
    end else begin
      state      <= state_next;
      exp_addr   <= exp_next;
      run_max    <= run_max_next;
      run_bin    <= run_bin_next;
      peak_valid <= (state == REPORT);
      if (state == REPORT) begin
        peak_bin <= run_bin;
        peak_mag <= run_max;
      end
    end
  end

  note_stabilizer #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_stab (
    .clk         (clk),
    .reset_n     (reset_n),
    .peak_bin    (peak_bin),
    .peak_mag    (peak_mag),
    .peak_valid  (peak_valid),
    .threshold   (threshold),
    .note_bin    (note_bin),
    .note_on     (note_on),
    .note_change (note_change)
  );

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - frame-level model bench for fft_peak_detect
module tb_fft_peak_detect;

  localparam int SF = 3;
  localparam int LO = 2;
  localparam int HI = 1023;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hwe = 1'b0;
  logic [11:0] haddr = '0;
  logic [15:0] hdata = '0;
  logic [15:0] threshold = 16'd100;
  logic [10:0] peak_bin, note_bin;
  logic [15:0] peak_mag;
  logic        peak_valid, note_on, note_change;

  fft_peak_detect #(
    .ADDR_W(11), .DATA_W(16), .BIN_LO(LO), .BIN_HI(HI), .STABLE_FRAMES(SF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hwe(hwe), .haddr(haddr), .hdata(hdata),
    .threshold(threshold), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_valid(peak_valid), .note_bin(note_bin), .note_on(note_on),
    .note_change(note_change)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int bin; int mag;} exp_t;
  exp_t q[$];

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  n_pulses = 0;
  int  n_chg = 0;
  bit  rst_q = 1'b1;
  int  mag[2048];

  // model state: held peak, stable note, candidate run (-1 = silence)
  int  h_bin = 0, h_mag = 0;
  int  m_on = 0, m_nbin = 0, m_cand = -1, m_run = 0;
  bit  pend = 0;
  int  p_on, p_nbin, p_chg;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= !reset_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   exp_chg;
    bit   exp_v;
    bit   hit;
    if (rst_q) begin
      check("rst_peak_bin", 32'(peak_bin), 0);
      check("rst_peak_mag", 32'(peak_mag), 0);
      check("rst_peak_valid", 32'(peak_valid), 0);
      check("rst_note_bin", 32'(note_bin), 0);
      check("rst_note_on", 32'(note_on), 0);
      check("rst_note_change", 32'(note_change), 0);
      q.delete();
      h_bin = 0; h_mag = 0; m_on = 0; m_nbin = 0; m_cand = -1; m_run = 0; pend = 0;
    end else begin
      exp_chg = 0;
      if (pend) begin
        m_on = p_on; m_nbin = p_nbin; exp_chg = p_chg; pend = 0;
      end
      check("note_change", 32'(note_change), 32'(exp_chg));
      check("note_on", 32'(note_on), 32'(m_on));
      check("note_bin", 32'(note_bin), 32'(m_nbin));
      if (note_change === 1'b1) n_chg++;

      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("peak_valid", 32'(peak_valid), 32'(exp_v));
      if (peak_valid === 1'b1) n_pulses++;
      if (exp_v) begin
        e = q.pop_front();
        h_bin = e.bin; h_mag = e.mag;
        hit = (h_mag >= int'(threshold));
        if (hit) begin
          if (m_run > 0 && m_cand >= 0 && (h_bin - m_cand <= 1) && (m_cand - h_bin <= 1)) m_run++;
          else begin m_cand = h_bin; m_run = 1; end
        end else begin
          if (m_run > 0 && m_cand < 0) m_run++;
          else begin m_cand = -1; m_run = 1; end
        end
        if (m_run > SF) m_run = SF;
        p_on = m_on; p_nbin = m_nbin; p_chg = 0;
        if (m_run == SF && hit && (m_on == 0 || m_cand != m_nbin)) begin
          p_on = 1; p_nbin = m_cand; p_chg = 1;
        end else if (m_run == SF && !hit && m_on == 1) begin
          p_on = 0; p_chg = 1;
        end
        pend = 1;
      end else if (q.size() > 0 && q[0].due < cyc) begin
        void'(q.pop_front());
      end
      check("peak_bin", 32'(peak_bin), 32'(h_bin));
      check("peak_mag", 32'(peak_mag), 32'(h_mag));
    end
  end

  task automatic send(input int a, input int d);
    hwe = 1'b1; haddr = 12'(a); hdata = 16'(d);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    hwe = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 2048; i++) mag[i] = v;
  endtask

  task automatic one_peak(input int b, input int v);
    fill(0);
    mag[b] = v;
  endtask

  // skip_at drops one address from the stream; rst_at pulses reset with that write
  task automatic run_frame(input int skip_at, input int rst_at);
    int bb = 0;
    int bm = 0;
    for (int b = LO; b <= HI; b++) if (mag[b] > bm) begin bm = mag[b]; bb = b; end
    for (int a = 0; a < 2048; a++) begin
      if (a == skip_at) continue;
      if (a == rst_at) reset_n = 1'b0;
      send(a, mag[a]);
      reset_n = 1'b1;
    end
    if (skip_at < 0 && rst_at < 0) q.push_back('{cyc + 1, bb, bm});
  endtask

  initial begin
    int p0, c0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    fill(10); mag[100] = 500;
    p0 = n_pulses;
    run_frame(-1, -1); idle(4);
    check("lit_single_pulse", 32'(n_pulses - p0), 1);
    check("lit_peak_bin_100", 32'(peak_bin), 100);
    check("lit_peak_mag_500", 32'(peak_mag), 500);

    fill(0); mag[50] = 700; mag[60] = 700;
    run_frame(-1, -1); idle(4);
    check("lit_tie_low_bin", 32'(peak_bin), 50);

    fill(3); mag[1] = 9000; mag[1500] = 9000; mag[400] = 20;
    run_frame(-1, -1); idle(4);
    check("lit_window_bin", 32'(peak_bin), 400);
    check("lit_window_mag", 32'(peak_mag), 20);

    fill(0); mag[700] = 1234;
    p0 = n_pulses;
    run_frame(301, -1); idle(4);
    check("lit_jump_no_pulse", 32'(n_pulses - p0), 0);
    run_frame(-1, -1); idle(4);
    check("lit_after_jump_bin", 32'(peak_bin), 700);
    check("lit_after_jump_mag", 32'(peak_mag), 1234);

    reset_n = 1'b0; idle(1); reset_n = 1'b1; idle(2);
    threshold = 16'd100;
    c0 = n_chg; p0 = n_pulses;
    one_peak(80, 200); run_frame(-1, -1);
    one_peak(81, 200); run_frame(-1, -1);
    one_peak(80, 200); run_frame(-1, -1);
    idle(4);
    check("lit_b2b_pulses", 32'(n_pulses - p0), 3);
    check("lit_note_on", 32'(note_on), 1);
    check("lit_note_bin_80", 32'(note_bin), 80);
    check("lit_note_change_on", 32'(n_chg - c0), 1);

    c0 = n_chg;
    for (int i = 0; i < 3; i++) begin one_peak(80, 50); run_frame(-1, -1); end
    idle(4);
    check("lit_note_off", 32'(note_on), 0);
    check("lit_note_bin_hold", 32'(note_bin), 80);
    check("lit_note_change_off", 32'(n_chg - c0), 1);

    c0 = n_chg;
    for (int i = 0; i < 4; i++) begin
      one_peak((i % 2 == 0) ? 80 : 200, 200);
      run_frame(-1, -1);
    end
    idle(4);
    check("lit_alternate_no_change", 32'(n_chg - c0), 0);

    fill(1); mag[600] = 777;
    p0 = n_pulses;
    run_frame(-1, 900); idle(4);
    check("lit_reset_no_pulse", 32'(n_pulses - p0), 0);
    check("lit_reset_peak_bin", 32'(peak_bin), 0);
    run_frame(-1, -1); idle(4);
    check("lit_post_reset_bin", 32'(peak_bin), 600);
    check("lit_post_reset_mag", 32'(peak_mag), 777);
    check("lit_queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Streaming peak picker on the FFT magnitude write stream from `process_fft`, tapped in parallel with the histogram BRAM write port in the 104 MHz domain. It tracks the strongest bin inside a configurable frequency window over each complete frame and reports it once per frame. A stabiliser stage then turns per-frame peaks into a debounced note output (`note_bin`, `note_on`, `note_change`) for the game logic downstream.

## Interface
- `ADDR_W`, 11, bin index width (2048 bins per frame).
- `DATA_W`, 16, magnitude width.
- `BIN_LO`, 2, lowest bin considered; excludes DC and near-DC.
- `BIN_HI`, 1023, highest bin considered (inclusive).
- `STABLE_FRAMES`, 3, consecutive agreeing frames required to change note state; 1..15.
- `clk`  in  1  104 MHz system clock; the single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `hwe`  in  1  bin write strobe from `process_fft`.
- `haddr`  in  12  bin address; only `[ADDR_W-1:0]` is used.
- `hdata`  in  DATA_W  bin magnitude.
- `threshold`  in  DATA_W  minimum peak magnitude that counts as a note.
- `peak_bin`  out  ADDR_W  bin of the last reported frame peak.
- `peak_mag`  out  DATA_W  magnitude of that peak.
- `peak_valid`  out  1  one-cycle pulse per completed good frame.
- `note_bin`  out  ADDR_W  current stable note bin.
- `note_on`  out  1  a stable note is present.
- `note_change`  out  1  one-cycle pulse when `note_on` or `note_bin` changes.

## Operation
- Single clock; reset is synchronous and active-low. Every output resets to 0. Reset also clears `run_max`, `run_bin`, `cand_bin`, `count`, and returns the FSM to WAIT_START.
- FSM states:
  - WAIT_START: ignore every write except `hwe && a==0`. That write moves to SCAN with `expect=1`, `run_max=0`, `run_bin=0`.
  - SCAN, on each `hwe`:
    - `a != expect`: abort to WAIT_START with no pulse. If that same write has `a==0`, it is taken as a fresh frame start.
    - Otherwise `expect++`.
    - If `BIN_LO<=a<=BIN_HI` and `hdata>run_max` (strict greater-than, so on a tie the lower bin wins), load `run_max=hdata`, `run_bin=a`.
    - `a==2^ADDR_W-1` ends the frame and moves to REPORT.
  - REPORT, one cycle: load `peak_bin=run_bin` and `peak_mag=run_max`, pulse `peak_valid`, then go to WAIT_START.
- Back-to-back frames: a `hwe` with `a==0` that arrives during the REPORT cycle is accepted as the next frame start. No write may be lost.
- A frame with no in-window write above 0 reports `peak_bin=0`, `peak_mag=0`.
- Stabiliser, evaluated on `peak_valid`:
  - `hit = peak_mag >= threshold` (unsigned).
  - On a hit:
    - If `count!=0` and `|peak_bin - cand_bin| <= 1`, then `count++`.
    - Otherwise `cand_bin=peak_bin` and `count=1`.
  - On a miss: if `cand` is a silence candidate, `count++`; otherwise `cand` becomes silence and `count=1`.
  - `count` saturates at `STABLE_FRAMES`.
  - When `count` reaches `STABLE_FRAMES` on a hit, and (`!note_on` or `cand_bin != note_bin`): set `note_on=1`, `note_bin=cand_bin`, pulse `note_change`.
  - When `count` reaches `STABLE_FRAMES` on a miss and `note_on`: set `note_on=0` and pulse `note_change`. `note_bin` holds its last value.
- `threshold` is sampled only on `peak_valid` and may change at any time.

## Timing
- Final-bin write sampled at edge E. REPORT is active during the following cycle. `peak_*` update and `peak_valid` is high for exactly one cycle after edge E+1.
- Note outputs update one cycle after `peak_valid`. `note_change` is high for one cycle.
- Minimum latency from a sustained note to `note_on` is `STABLE_FRAMES` frames plus 2 cycles after the final frame's last write.
- `hwe` may be high every cycle. Throughput is one bin per cycle, with zero stall and no back-pressure.

## Structure
- `ghffe_pkg` holds `BIN_ADDR_W`, `MAG_W`, and the `peak_state_t` enum (WAIT_START, SCAN, REPORT). `xvga`/`histogram` users share the same widths.
- Sub-module `note_stabilizer` implements the candidate/count/note logic. Its inputs are `peak_bin`, `peak_mag`, `peak_valid` and `threshold`.
- `fft_peak_detect` contains the FSM and the running-max datapath.

## Test plan
- Frame 0..2047 with all bins 10 except bin 100=500 → `peak_valid` once, `peak_bin=100`, `peak_mag=500`.
- Bins 50 and 60 both =700, rest 0 → `peak_bin=50`. Bin 1=9000 and bin 1500=9000 with the in-window maximum 20 → peak 20; out-of-window bins are ignored.
- Frame with address jump 300→302 → no `peak_valid`. The next clean frame reports normally.
- `threshold=100`, `STABLE_FRAMES=3`:
  - Peaks 200@bin 80, 81, 80 → after the third frame, `note_on=1`, `note_bin=80` (the first candidate), one `note_change`.
  - Then three frames with peak 50 → `note_on=0`, one `note_change`.
  - Alternating bins 80/200 → no `note_change`.
- `reset_n` low for 1 cycle mid-SCAN at bin 900 → all outputs 0 the next cycle. Writes 901..2047 are ignored. The following frame from 0 reports correctly.
- Continuous back-to-back frames with `hwe` high every cycle → one `peak_valid` per frame and no dropped frame start.
